// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM fade scheduler.
package pwm_pkg;
  localparam int DEF_DUTY_BITS = 19;

  typedef logic [DEF_DUTY_BITS-1:0] duty_t;

  localparam duty_t DUTY_MAX = '1;

  typedef enum logic {IDLE, UPDATE} sched_state_t;
endpackage

// File: rtl/pwm_fade_sched_if.sv
// Command port of the fade scheduler: one valid/ready transfer sets a channel's target and step.
interface pwm_fade_sched_if #(
  parameter int CHANNELS  = 4,
  parameter int DUTY_BITS = 19
);
  localparam int CW = $clog2(CHANNELS);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CW-1:0]        cmd_ch;
  logic [DUTY_BITS-1:0] cmd_target;
  logic [DUTY_BITS-1:0] cmd_step;

  modport master (output cmd_valid, cmd_ch, cmd_target, cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_target, cmd_step, output cmd_ready);
endinterface

// File: rtl/pwm_step_sat.sv
// Saturating one-step move of a duty value toward its target (combinational).
module pwm_step_sat #(
  parameter int W = 19
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] nxt,
  output logic         reached
);
  logic [W:0] sum, diff;

  // One extra bit catches carry out of the add and borrow out of the subtract.
  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    nxt  = cur;
    if (cur < tgt) begin
      nxt = (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
    end else if (cur > tgt) begin
      nxt = (diff[W] || (diff[W-1:0] <= tgt)) ? tgt : diff[W-1:0];
    end
    reached = (cur != tgt) && (nxt == tgt);
  end
endmodule

// File: rtl/pwm_fade_sched.sv
// Multi-channel fade scheduler: per prescaler tick, one scan walks all channels through a shared step engine.
module pwm_fade_sched
  import pwm_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int DUTY_BITS     = 19,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                                clk50,
  input  logic                                rst,
  pwm_fade_sched_if.slave                     cmd,
  output logic [CHANNELS-1:0][DUTY_BITS-1:0]  duty,
  output logic [CHANNELS-1:0]                 busy,
  output logic [CHANNELS-1:0]                 done
);
  localparam int CW = $clog2(CHANNELS);

  logic [PRESCALE_BITS-1:0]            presc_q, presc_d;
  sched_state_t                        state_q, state_d;
  logic [CW-1:0]                       idx_q, idx_d;
  logic [CHANNELS-1:0][DUTY_BITS-1:0]  duty_q, duty_d;
  logic [CHANNELS-1:0][DUTY_BITS-1:0]  tgt_q, tgt_d;
  logic [CHANNELS-1:0][DUTY_BITS-1:0]  step_q, step_d;
  logic [CHANNELS-1:0]                 busy_q, busy_d;
  logic [CHANNELS-1:0]                 done_q, done_d;

  logic                 tick;
  logic [DUTY_BITS-1:0] eng_nxt;
  logic                 eng_reached;

  assign tick          = &presc_q;
  assign cmd.cmd_ready = (state_q == IDLE);
  assign duty          = duty_q;
  assign busy          = busy_q;
  assign done          = done_q;

  pwm_step_sat #(.W(DUTY_BITS)) u_step (
    .cur     (duty_q[idx_q]),
    .tgt     (tgt_q[idx_q]),
    .step    (step_q[idx_q]),
    .nxt     (eng_nxt),
    .reached (eng_reached)
  );

  // Next-state: command intake while idle, one channel stepped per cycle while scanning.
  always_comb begin
    presc_d = presc_q + PRESCALE_BITS'(1);
    state_d = state_q;
    idx_d   = idx_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          tgt_d[cmd.cmd_ch]  = cmd.cmd_target;
          step_d[cmd.cmd_ch] = cmd.cmd_step;
          if (cmd.cmd_step == '0) begin
            // Zero step is an immediate jump; it never shows as busy.
            duty_d[cmd.cmd_ch] = cmd.cmd_target;
            busy_d[cmd.cmd_ch] = 1'b0;
            done_d[cmd.cmd_ch] = (cmd.cmd_target != duty_q[cmd.cmd_ch]);
          end else begin
            busy_d[cmd.cmd_ch] = (cmd.cmd_target != duty_q[cmd.cmd_ch]);
          end
        end
        // A command on the tick edge lands first; the scan then sees the new target.
        if (tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        duty_d[idx_q] = eng_nxt;
        if (eng_reached) begin
          busy_d[idx_q] = 1'b0;
          done_d[idx_q] = 1'b1;
        end
        idx_d = idx_q + CW'(1);
        if (idx_q == CW'(CHANNELS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any ramp in flight.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_pwm_fade_sched.sv
// Bench for pwm_fade_sched: edge-indexed behavioural model plus directed scenarios with literal checks.
module tb_pwm_fade_sched;
  localparam int CH = 4;
  localparam int DB = 8;
  localparam int PB = 4;
  localparam int PERIOD = 1 << PB;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  logic [CH-1:0][DB-1:0] duty;
  logic [CH-1:0]         busy, done;

  pwm_fade_sched_if #(.CHANNELS(CH), .DUTY_BITS(DB)) cif ();

  pwm_fade_sched #(.CHANNELS(CH), .DUTY_BITS(DB), .PRESCALE_BITS(PB)) dut (
    .clk50 (clk50),
    .rst   (rst),
    .cmd   (cif),
    .duty  (duty),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk50 = ~clk50;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: edge e (counted from reset release) is a scan edge for channel e%PERIOD
  // when e>=PERIOD and e%PERIOD<CH; the command port is closed on exactly those edges.
  typedef struct packed {
    logic [CH-1:0][DB-1:0] duty;
    logic [CH-1:0][DB-1:0] tgt;
    logic [CH-1:0][DB-1:0] step;
    logic [CH-1:0]         busy;
    logic [CH-1:0]         done;
  } mst_t;

  mst_t ms;
  int   m_e;

  function automatic bit scan_edge(input int e);
    return (e >= PERIOD) && ((e % PERIOD) < CH);
  endfunction

  function automatic mst_t model_step(input mst_t s, input int e, input logic v,
                                      input logic [1:0] ch, input logic [DB-1:0] t,
                                      input logic [DB-1:0] st);
    mst_t n = s;
    int k, cur, tg, sp, nx;
    n.done = '0;
    if (scan_edge(e)) begin
      k  = e % PERIOD;
      cur = int'(s.duty[k]);
      tg  = int'(s.tgt[k]);
      sp  = int'(s.step[k]);
      if (cur < tg)      nx = (cur + sp > tg) ? tg : cur + sp;
      else if (cur > tg) nx = (cur - sp < tg) ? tg : cur - sp;
      else               nx = cur;
      n.duty[k] = DB'(nx);
      if (cur != tg && nx == tg) begin
        n.busy[k] = 1'b0;
        n.done[k] = 1'b1;
      end
    end else if (v) begin
      n.tgt[ch]  = t;
      n.step[ch] = st;
      if (st == '0) begin
        n.done[ch] = (t != s.duty[ch]);
        n.duty[ch] = t;
        n.busy[ch] = 1'b0;
      end else begin
        n.busy[ch] = (t != s.duty[ch]);
      end
    end
    return n;
  endfunction

  // Model advance on every clock edge.
  always @(posedge clk50 or posedge rst) begin
    if (rst) begin
      ms  <= '0;
      m_e <= 0;
    end else begin
      ms  <= model_step(ms, m_e, cif.cmd_valid, cif.cmd_ch, cif.cmd_target, cif.cmd_step);
      m_e <= m_e + 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk50) begin
    if (!rst) begin
      chk("duty", 32'(duty), 32'(ms.duty));
      chk("busy", 32'(busy), 32'(ms.busy));
      chk("done", 32'(done), 32'(ms.done));
      chk("cmd_ready", 32'(cif.cmd_ready), 32'(!scan_edge(m_e)));
    end
  end

  task automatic goto_e(input int n);
    for (int i = 0; i < 2000 && m_e < n; i++) @(negedge clk50);
    chk("timeline", m_e, n);
  endtask

  task automatic send(input int ch, input int t, input int st, output int nr);
    bit ok = 0;
    nr = 0;
    cif.cmd_valid  = 1'b1;
    cif.cmd_ch     = 2'(ch);
    cif.cmd_target = DB'(t);
    cif.cmd_step   = DB'(st);
    for (int i = 0; i < 40; i++) begin
      if (cif.cmd_ready) begin
        ok = 1;
        @(posedge clk50);
        #1;
        break;
      end
      nr++;
      @(posedge clk50);
      #1;
    end
    cif.cmd_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: ch %0d never accepted", ch);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk50);
    #3 rst = 1'b1;
    #1;
    chk("rst_duty", 32'(duty), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(cif.cmd_ready), 32'h1);
    @(negedge clk50);
    rst = 1'b0;
  endtask

  initial begin
    int nr;
    cif.cmd_valid  = 1'b0;
    cif.cmd_ch     = '0;
    cif.cmd_target = '0;
    cif.cmd_step   = '0;
    repeat (3) @(negedge clk50);
    chk("init_duty", 32'(duty), 32'h0);
    chk("init_ready", 32'(cif.cmd_ready), 32'h1);
    rst = 1'b0;

    // Reset in the middle of a ramp.
    send(0, 200, 10, nr);
    goto_e(50);
    chk("ramp0_duty", 32'(duty[0]), 32'd30);
    chk("ramp0_busy", 32'(busy[0]), 32'd1);
    pulse_reset();

    // Up ramp that clamps at the target.
    send(1, 25, 10, nr);
    goto_e(18);
    chk("up_t1", 32'(duty[1]), 32'd10);
    goto_e(34);
    chk("up_t2", 32'(duty[1]), 32'd20);
    goto_e(50);
    chk("up_t3", 32'(duty[1]), 32'd25);
    chk("up_done", 32'(done), 32'b0010);
    goto_e(51);
    chk("up_done_end", 32'(done[1]), 32'd0);
    chk("up_busy_end", 32'(busy[1]), 32'd0);

    // Jump to full scale, then ramp down without underflow.
    goto_e(56);
    send(2, 255, 0, nr);
    chk("jump_duty", 32'(duty[2]), 32'd255);
    chk("jump_done", 32'(done), 32'b0100);
    chk("jump_busy", 32'(busy[2]), 32'd0);
    send(2, 0, 100, nr);
    goto_e(67);
    chk("dn_t1", 32'(duty[2]), 32'd155);
    goto_e(83);
    chk("dn_t2", 32'(duty[2]), 32'd55);
    goto_e(99);
    chk("dn_t3", 32'(duty[2]), 32'd0);
    chk("dn_done", 32'(done), 32'b0100);

    // Command on the tick edge, then a command stalled by the scan.
    goto_e(111);
    send(3, 50, 20, nr);
    chk("tick_nr", nr, 0);
    send(0, 5, 5, nr);
    chk("stall_cycles", nr, 4);
    chk("tick_same_scan", 32'(duty[3]), 32'd20);

    // Retarget a busy channel mid-ramp.
    goto_e(136);
    send(3, 10, 15, nr);
    goto_e(148);
    chk("retgt_t1", 32'(duty[3]), 32'd25);
    chk("retgt_busy", 32'(busy[3]), 32'd1);
    goto_e(164);
    chk("retgt_t2", 32'(duty[3]), 32'd10);
    chk("retgt_done", 32'(done), 32'b1000);

    // Round-robin timing across all channels.
    pulse_reset();
    for (int k = 0; k < CH; k++) send(k, 3, 1, nr);
    goto_e(17);
    chk("rr_ch0_first", 32'(duty), 32'h0000_0001);
    goto_e(18);
    chk("rr_ch1_next", 32'(duty), 32'h0000_0101);
    goto_e(49);
    chk("rr_done0", 32'(done), 32'b0001);
    goto_e(50);
    chk("rr_done1", 32'(done), 32'b0010);
    goto_e(51);
    chk("rr_done2", 32'(done), 32'b0100);
    goto_e(52);
    chk("rr_done3", 32'(done), 32'b1000);
    chk("rr_final", 32'(duty), 32'h0303_0303);

    // Upward step that would wrap in DUTY_BITS must clamp at the target.
    send(0, 255, 255, nr);
    goto_e(65);
    chk("no_wrap_duty", 32'(duty[0]), 32'd255);
    chk("no_wrap_done", 32'(done), 32'b0001);

    repeat (4) @(negedge clk50);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
